// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer.
// Contents: default geometry (depth, address width, data width), the RISC-V
// store funct3 size codes, and the fence-sequencing FSM state encoding.
package store_buffer_pkg;

    localparam int SB_DEPTH     = 4;
    localparam int SB_ADDR_SIZE = 32;
    localparam int SB_WORD_LEN  = 32;

    // Store size codes (funct3); carried through untouched to data memory
    localparam logic [2:0] FUNCT3_SB = 3'b000;
    localparam logic [2:0] FUNCT3_SH = 3'b001;
    localparam logic [2:0] FUNCT3_SW = 3'b010;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        FENCE  = 2'd1,
        DONE   = 2'd2
    } sb_state_e;

endpackage

// File: rtl/store_buffer_if.sv
// Store buffer bus bundle.
// Groups the MEM-stage store request, the load hazard probe, the data-memory
// write port and the fence/status signals.
//   master : pipeline side (drives requests, grant and fence; observes status)
//   slave  : store buffer side
interface store_buffer_if
    import store_buffer_pkg::*;
#(
    parameter int DEPTH     = SB_DEPTH,
    parameter int ADDR_SIZE = SB_ADDR_SIZE,
    parameter int WORD_LEN  = SB_WORD_LEN
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                 stValid;
    logic [ADDR_SIZE-1:0] stAddr;
    logic [2:0]           stSize;
    logic [WORD_LEN-1:0]  stData;
    logic [ADDR_SIZE-1:0] stPc;
    logic                 stReady;
    logic                 ldValid;
    logic [ADDR_SIZE-1:0] ldAddr;
    logic                 ldHazard;
    logic                 memGrant;
    logic                 memWriteEnable;
    logic [ADDR_SIZE-1:0] memAddr;
    logic [2:0]           memUnitSize;
    logic [WORD_LEN-1:0]  memWriteData;
    logic [ADDR_SIZE-1:0] memPc;
    logic                 fenceReq;
    logic                 fenceDone;
    logic                 empty;
    logic [CNT_W-1:0]     count;

    modport master (
        output stValid, stAddr, stSize, stData, stPc, ldValid, ldAddr, memGrant, fenceReq,
        input  stReady, ldHazard, memWriteEnable, memAddr, memUnitSize, memWriteData, memPc,
               fenceDone, empty, count
    );

    modport slave (
        input  stValid, stAddr, stSize, stData, stPc, ldValid, ldAddr, memGrant, fenceReq,
        output stReady, ldHazard, memWriteEnable, memAddr, memUnitSize, memWriteData, memPc,
               fenceDone, empty, count
    );

endinterface

// File: rtl/store_buffer_match.sv
// Word-granular address comparators for load hazard detection.
// Ports:
//   entry_word  : word address (byte address >> 2) of every buffer slot
//   entry_valid : slot occupancy mask
//   ld_word     : word address of the load in MEM
//   hit         : some occupied slot targets the same word
module store_buffer_match #(
    parameter int DEPTH  = 4,
    parameter int WORD_W = 30
) (
    input  logic [DEPTH-1:0][WORD_W-1:0] entry_word,
    input  logic [DEPTH-1:0]             entry_valid,
    input  logic [WORD_W-1:0]            ld_word,
    output logic                         hit
);

    // OR-reduce the per-slot compares; only occupied slots may hit
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entry_word[i] == ld_word)) begin
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between the MEM stage and the data-memory write port.
// Ports:
//   clk  : single clock, all state on the rising edge
//   rstn : synchronous active-low reset
//   sb   : store_buffer_if slave (store request, load probe, memory write
//          port, fence handshake, empty/count status)
// Stores are queued in a circular FIFO and retired oldest-first whenever the
// memory port is granted. A fence blocks new stores until the FIFO drains and
// then pulses fenceDone for one cycle.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH     = SB_DEPTH,
    parameter int ADDR_SIZE = SB_ADDR_SIZE,
    parameter int WORD_LEN  = SB_WORD_LEN
) (
    input logic         clk,
    input logic         rstn,
    store_buffer_if.slave sb
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [DEPTH-1:0]     valid_q, valid_d;
    sb_state_e            state_q, state_d;
    logic [ADDR_SIZE-1:0] addr_q [DEPTH];
    logic [ADDR_SIZE-1:0] addr_d [DEPTH];
    logic [2:0]           size_q [DEPTH];
    logic [2:0]           size_d [DEPTH];
    logic [WORD_LEN-1:0]  data_q [DEPTH];
    logic [WORD_LEN-1:0]  data_d [DEPTH];
    logic [ADDR_SIZE-1:0] pc_q   [DEPTH];
    logic [ADDR_SIZE-1:0] pc_d   [DEPTH];

    logic                               st_ready_s, push_s, pop_s, hit_s;
    logic [DEPTH-1:0][ADDR_SIZE-3:0]    entry_word_s;
    logic [1:0]                         unused_ld_low_s;

    // FIFO bookkeeping: enqueue at tail, retire at head
    always_comb begin
        st_ready_s = (count_q < CNT_W'(DEPTH)) && (state_q == NORMAL);
        push_s     = sb.stValid && st_ready_s;
        // no write may leave during a reset cycle
        pop_s      = (count_q != {CNT_W{1'b0}}) && sb.memGrant && rstn;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        valid_d    = valid_q;
        addr_d     = addr_q;
        size_d     = size_q;
        data_d     = data_q;
        pc_d       = pc_q;
        if (push_s) begin
            addr_d[tail_q]  = sb.stAddr;
            size_d[tail_q]  = sb.stSize;
            data_d[tail_q]  = sb.stData;
            pc_d[tail_q]    = sb.stPc;
            valid_d[tail_q] = 1'b1;
            tail_d = (tail_q == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : tail_q + PTR_W'(1);
        end else begin
            tail_d = tail_q;
        end
        // push and pop never share a slot: pop needs an entry, push needs a free one
        if (pop_s) begin
            valid_d[head_q] = 1'b0;
            head_d = (head_q == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : head_q + PTR_W'(1);
        end else begin
            head_d = head_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Fence sequencing; FENCE looks at count_d so a drain on the same edge counts
    always_comb begin
        state_d = state_q;
        case (state_q)
            NORMAL: begin
                if (sb.fenceReq) state_d = FENCE;
                else             state_d = NORMAL;
            end
            FENCE: begin
                if (count_d == {CNT_W{1'b0}}) state_d = DONE;
                else                          state_d = FENCE;
            end
            DONE:    state_d = NORMAL;
            default: state_d = NORMAL;
        endcase
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
            valid_q <= {DEPTH{1'b0}};
            state_q <= NORMAL;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            state_q <= state_d;
        end
    end

    // Entry payload storage; occupancy lives in valid_q so no reset is needed
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        size_q <= size_d;
        data_q <= data_d;
        pc_q   <= pc_d;
    end

    // Word addresses of all slots for the hazard comparators
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_word_s[i] = addr_q[i][ADDR_SIZE-1:2];
        end
        unused_ld_low_s = sb.ldAddr[1:0];
    end

    store_buffer_match #(
        .DEPTH  (DEPTH),
        .WORD_W (ADDR_SIZE - 2)
    ) u_match (
        .entry_word  (entry_word_s),
        .entry_valid (valid_q),
        .ld_word     (sb.ldAddr[ADDR_SIZE-1:2]),
        .hit         (hit_s)
    );

    // Outputs: memory port presents the head entry directly
    always_comb begin
        sb.stReady        = st_ready_s;
        sb.memWriteEnable = pop_s;
        sb.memAddr        = addr_q[head_q];
        sb.memUnitSize    = size_q[head_q];
        sb.memWriteData   = data_q[head_q];
        sb.memPc          = pc_q[head_q];
        sb.ldHazard       = sb.ldValid && hit_s;
        sb.fenceDone      = (state_q == DONE);
        sb.empty          = (count_q == {CNT_W{1'b0}});
        sb.count          = count_q;
    end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    localparam int D = 4;

    logic clk;
    logic rstn;

    store_buffer_if #(.DEPTH(D), .ADDR_SIZE(32), .WORD_LEN(32)) sbif ();

    store_buffer #(.DEPTH(D), .ADDR_SIZE(32), .WORD_LEN(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .sb   (sbif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
        logic [31:0] pc;
    } ent_t;

    // reference model: an ordered list of pending stores plus fence phase
    ent_t m_q[$];
    bit   m_valid  = 1'b0;
    bit   m_fence  = 1'b0;
    bit   m_done   = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   dut_writes = 0;
    int   max_dut_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // compare every DUT output with what the model says, mid-cycle
    task automatic settle();
        logic exp_ready, exp_we, exp_hz;
        @(negedge clk);
        if (m_valid) begin
            exp_ready = (m_q.size() < D) && !m_fence && !m_done;
            exp_we    = rstn && sbif.memGrant && (m_q.size() > 0);
            exp_hz    = 1'b0;
            foreach (m_q[i]) begin
                if (sbif.ldValid && (m_q[i].addr[31:2] == sbif.ldAddr[31:2])) exp_hz = 1'b1;
            end
            chk("stReady", sbif.stReady, exp_ready);
            chk("memWriteEnable", sbif.memWriteEnable, exp_we);
            chk("ldHazard", sbif.ldHazard, exp_hz);
            chk("fenceDone", sbif.fenceDone, m_done);
            chk("empty", sbif.empty, m_q.size() == 0);
            chk("count", sbif.count, m_q.size());
            if (m_q.size() > 0) begin
                chk("memAddr", sbif.memAddr, m_q[0].addr);
                chk("memUnitSize", sbif.memUnitSize, m_q[0].size);
                chk("memWriteData", sbif.memWriteData, m_q[0].data);
                chk("memPc", sbif.memPc, m_q[0].pc);
            end
            if (sbif.memWriteEnable === 1'b1) dut_writes++;
            if (int'(sbif.count) > max_dut_cnt) max_dut_cnt = int'(sbif.count);
        end
    endtask

    // advance the model across the rising edge, then let stimulus change
    task automatic step();
        bit push, pop;
        @(posedge clk);
        if (!rstn) begin
            m_q.delete();
            m_fence = 1'b0;
            m_done  = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            push = sbif.stValid && (m_q.size() < D) && !m_fence && !m_done;
            pop  = sbif.memGrant && (m_q.size() > 0);
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back('{sbif.stAddr, sbif.stSize, sbif.stData, sbif.stPc});
            if (m_done) m_done = 1'b0;
            else if (m_fence) begin
                if (m_q.size() == 0) begin
                    m_fence = 1'b0;
                    m_done  = 1'b1;
                end
            end else if (sbif.fenceReq) m_fence = 1'b1;
        end
        #1;
    endtask

    task automatic cyc();
        settle();
        step();
    endtask

    task automatic set_st(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d, input logic [31:0] p);
        sbif.stValid = 1'b1;
        sbif.stAddr  = a;
        sbif.stSize  = s;
        sbif.stData  = d;
        sbif.stPc    = p;
    endtask

    task automatic drain_all();
        bit done;
        done = 1'b0;
        sbif.stValid  = 1'b0;
        sbif.memGrant = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            settle();
            done = (sbif.empty === 1'b1);
            step();
        end
        chk("drain_within_budget", done, 1'b1);
    endtask

    initial begin
        int sent, w0;
        rstn = 1'b0;
        sbif.stValid = 1'b0; sbif.stAddr = 32'h0; sbif.stSize = 3'b000;
        sbif.stData = 32'h0; sbif.stPc = 32'h0; sbif.ldValid = 1'b0;
        sbif.ldAddr = 32'h0; sbif.memGrant = 1'b0; sbif.fenceReq = 1'b0;
        step();
        step();
        rstn = 1'b1;
        // reset state, pinned by literals
        settle();
        chk("rst_stReady", sbif.stReady, 1'b1);
        chk("rst_empty", sbif.empty, 1'b1);
        chk("rst_count", sbif.count, 3'd0);
        chk("rst_we", sbif.memWriteEnable, 1'b0);
        chk("rst_fenceDone", sbif.fenceDone, 1'b0);
        step();

        // single store, no bypass, written the next cycle
        sbif.memGrant = 1'b1;
        set_st(32'h100, 3'b010, 32'hDEADBEEF, 32'h1000);
        settle();
        chk("st1_no_bypass", sbif.memWriteEnable, 1'b0);
        step();
        sbif.stValid = 1'b0;
        settle();
        chk("st1_we", sbif.memWriteEnable, 1'b1);
        chk("st1_addr", sbif.memAddr, 32'h100);
        chk("st1_data", sbif.memWriteData, 32'hDEADBEEF);
        step();
        settle();
        chk("st1_empty_after", sbif.empty, 1'b1);
        step();

        // fill to full, fifth store held until a drain frees a slot
        sbif.memGrant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_st(32'h200 + 32'(4 * i), 3'b010, 32'hA000 + 32'(i), 32'h2000 + 32'(4 * i));
            cyc();
        end
        set_st(32'h210, 3'b010, 32'hA004, 32'h2010);
        settle();
        chk("full_stReady", sbif.stReady, 1'b0);
        chk("full_count", sbif.count, 3'd4);
        step();
        sbif.memGrant = 1'b1;
        settle();
        chk("full_drain_no_enq", sbif.stReady, 1'b0);
        chk("full_first_addr", sbif.memAddr, 32'h200);
        step();
        settle();
        chk("full_ready_again", sbif.stReady, 1'b1);
        chk("full_count3", sbif.count, 3'd3);
        step();
        drain_all();

        // load hazard, word granular
        sbif.memGrant = 1'b0;
        set_st(32'h204, 3'b000, 32'h000000AB, 32'h3000);
        cyc();
        sbif.stValid = 1'b0;
        sbif.ldValid = 1'b1;
        sbif.ldAddr  = 32'h207;
        settle();
        chk("hz_same_word", sbif.ldHazard, 1'b1);
        step();
        sbif.ldAddr = 32'h208;
        settle();
        chk("hz_next_word", sbif.ldHazard, 1'b0);
        step();
        sbif.ldAddr   = 32'h207;
        sbif.memGrant = 1'b1;
        cyc();
        settle();
        chk("hz_after_drain", sbif.ldHazard, 1'b0);
        step();
        // store accepted this cycle is not compared
        set_st(32'h400, 3'b010, 32'h1, 32'h0);
        sbif.memGrant = 1'b0;
        sbif.ldAddr   = 32'h400;
        settle();
        chk("hz_same_cycle_store", sbif.ldHazard, 1'b0);
        step();
        sbif.ldValid = 1'b0;
        drain_all();

        // ten stores with alternating grant: pointer wrap, order kept by model
        sent = 0;
        w0 = dut_writes;
        max_dut_cnt = 0;
        for (int c = 0; c < 100 && sent < 10; c++) begin
            sbif.memGrant = c[0];
            set_st(32'h300 + 32'(4 * sent), 3'b010, 32'hC0 + 32'(sent), 32'h5000 + 32'(sent));
            settle();
            if (sbif.stReady === 1'b1) sent++;
            step();
        end
        chk("wrap_all_sent", sent, 10);
        drain_all();
        chk("wrap_writes", dut_writes - w0, 10);
        chk("wrap_max_count_le_depth", max_dut_cnt <= D, 1'b1);

        // fence while empty: done two cycles after request
        sbif.fenceReq = 1'b1;
        settle();
        chk("fe_c0_done", sbif.fenceDone, 1'b0);
        step();
        sbif.fenceReq = 1'b0;
        settle();
        chk("fe_c1_ready", sbif.stReady, 1'b0);
        step();
        settle();
        chk("fe_c2_done", sbif.fenceDone, 1'b1);
        step();
        settle();
        chk("fe_c3_done_clr", sbif.fenceDone, 1'b0);
        step();

        // fence with three pending stores
        sbif.memGrant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_st(32'h600 + 32'(4 * i), 3'b001, 32'hF0 + 32'(i), 32'h6000);
            cyc();
        end
        sbif.stValid  = 1'b0;
        sbif.fenceReq = 1'b1;
        sbif.memGrant = 1'b1;
        settle();
        chk("f3_c0_we", sbif.memWriteEnable, 1'b1);
        step();
        sbif.fenceReq = 1'b0;
        settle();
        chk("f3_c1_ready", sbif.stReady, 1'b0);
        chk("f3_c1_we", sbif.memWriteEnable, 1'b1);
        step();
        settle();
        chk("f3_c2_addr", sbif.memAddr, 32'h608);
        step();
        settle();
        chk("f3_c3_done", sbif.fenceDone, 1'b1);
        chk("f3_c3_we", sbif.memWriteEnable, 1'b0);
        step();
        settle();
        chk("f3_c4_ready", sbif.stReady, 1'b1);
        step();

        // reset with stores pending discards them
        sbif.memGrant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_st(32'h700 + 32'(4 * i), 3'b010, 32'h77 + 32'(i), 32'h7000);
            cyc();
        end
        sbif.stValid  = 1'b0;
        rstn          = 1'b0;
        sbif.memGrant = 1'b1;
        settle();
        chk("rs_we_in_reset", sbif.memWriteEnable, 1'b0);
        step();
        rstn = 1'b1;
        settle();
        chk("rs_count", sbif.count, 3'd0);
        chk("rs_empty", sbif.empty, 1'b1);
        chk("rs_we", sbif.memWriteEnable, 1'b0);
        step();
        settle();
        chk("rs_we_later", sbif.memWriteEnable, 1'b0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
